// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer sampled on TickClk rising edges; emits a clean level plus press/release pulses.
// Define BTN_DEBOUNCE_REPEAT_EN to add hold-to-repeat press pulses.
module btn_debounce_pulse #(
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 1000,
  parameter int REPEAT_RATE  = 200,
  parameter int CNT_W        = 12
) (
  input  logic Clk,
  input  logic Rst,
  input  logic TickClk,
  input  logic BtnIn,
  output logic BtnLevel,
  output logic BtnPulse,
  output logic BtnRelease
);

  typedef enum logic [1:0] {
    Idle       = 2'd0,
    PressChk   = 2'd1,
    Held       = 2'd2,
    ReleaseChk = 2'd3
  } stateE;

  localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_TICKS);

  stateE            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, cntInc;
  logic             s1, s2, tickD, smp;
  logic             levelNext, pulseNext, releaseNext;
  logic             repeatHit;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      tickD <= 1'b0;
    end else begin
      // NOTE: non-blocking so s2 takes the previous s1, giving two real flops instead of one.
      s1    <= BtnIn;
      s2    <= s1;
      tickD <= TickClk;
    end
  end

  // One Clk-wide strobe per TickClk period, on its rising edge.
  assign smp    = TickClk & ~tickD;
  assign cntInc = cnt + 1'b1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= Idle;
      cnt        <= '0;
      BtnLevel   <= 1'b0;
      BtnPulse   <= 1'b0;
      BtnRelease <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      BtnLevel   <= levelNext;
      BtnPulse   <= pulseNext;
      BtnRelease <= releaseNext;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    stateNext = state;
    cntNext   = cnt;
    if (smp) begin
      unique case (state)
        Idle: begin
          if (s2) begin
            stateNext = PressChk;
            cntNext   = CNT_W'(1);
          end
        end
        PressChk: begin
          if (!s2) begin
            stateNext = Idle;
            cntNext   = '0;
          end else if (cntInc == StableCnt) begin
            stateNext = Held;
            cntNext   = '0;
          end else begin
            cntNext = cntInc;
          end
        end
        Held: begin
          if (!s2) begin
            stateNext = ReleaseChk;
            cntNext   = CNT_W'(1);
          end
        end
        ReleaseChk: begin
          if (s2) begin
            stateNext = Held;
            cntNext   = '0;
          end else if (cntInc == StableCnt) begin
            stateNext = Idle;
            cntNext   = '0;
          end else begin
            cntNext = cntInc;
          end
        end
      endcase
    end
  end

  // Outputs are registered from the next state so level and its pulse share one edge.
  always_comb begin
    levelNext   = (stateNext == Held) || (stateNext == ReleaseChk);
    pulseNext   = ((state == PressChk) && (stateNext == Held)) || repeatHit;
    releaseNext = (state == ReleaseChk) && (stateNext == Idle);
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RepeatAt     = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RepeatReload = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [CNT_W-1:0] rcnt, rcntNext, rcntInc;

  assign rcntInc   = rcnt + 1'b1;
  assign repeatHit = smp && (state == Held) && s2 && (rcntInc == RepeatAt);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) rcnt <= '0;
    else      rcnt <= rcntNext;
  end

  // Frozen outside Held, so a release bounce resumes the repeat schedule where it left off.
  always_comb begin
    rcntNext = rcnt;
    if (smp) begin
      if ((state == PressChk) && (stateNext == Held)) rcntNext = '0;
      else if ((state == Held) && s2)                 rcntNext = repeatHit ? RepeatReload : rcntInc;
    end
  end
`else
  logic unusedRepeatCfg;
  assign repeatHit       = 1'b0;
  assign unusedRepeatCfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: STABLE_TICKS=4, TickClk period 10 Clk.
// Each table step holds BtnIn for one tick period containing exactly one sample.
module tb_btn_debounce_pulse;

  localparam int StableTicks = 4;
  localparam int RepDelay    = 8;
  localparam int RepRate     = 3;
  localparam int NumVecs     = 30;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic TickClk = 1'b0;
  logic BtnIn = 1'b0;
  logic BtnLevel, BtnPulse, BtnRelease;
  bit   tickRun = 1'b1;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic btn;
    logic expLevel;
    int   expPulses;
    int   expReleases;
  } stepT;

  stepT vecs[NumVecs];

  btn_debounce_pulse #(
    .STABLE_TICKS(StableTicks),
    .REPEAT_DELAY(RepDelay),
    .REPEAT_RATE (RepRate),
    .CNT_W       (12)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .TickClk   (TickClk),
    .BtnIn     (BtnIn),
    .BtnLevel  (BtnLevel),
    .BtnPulse  (BtnPulse),
    .BtnRelease(BtnRelease)
  );

  always #5 Clk = ~Clk;

  // TickClk behaves like a Clk-domain register toggling every 5 Clk.
  initial forever begin
    repeat (5) @(posedge Clk);
    #1;
    if (tickRun) TickClk = ~TickClk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Level edges outside reset must coincide with the matching pulse.
  logic prevLevel = 1'b0;
  logic prevRst   = 1'b0;
  always @(negedge Clk) begin
    if (Rst && prevRst && (BtnLevel !== prevLevel)) begin
      if (BtnLevel === 1'b1) check("pulse_with_level_rise", BtnPulse, 1);
      else                   check("release_with_level_fall", BtnRelease, 1);
    end
    prevLevel = BtnLevel;
    prevRst   = Rst;
  end

  // Leaves us 5.5 Clk after a TickClk rise: the next sample lands mid-step.
  task automatic align();
    @(posedge TickClk);
    repeat (6) @(negedge Clk);
  endtask

  task automatic runStep(input logic btn, input logic expLevel, input int expP,
                         input int expR, input string tag);
    int p = 0;
    int r = 0;
    BtnIn = btn;
    repeat (10) begin
      @(negedge Clk);
      if (BtnPulse !== 1'b0)   p++;
      if (BtnRelease !== 1'b0) r++;
    end
    check({tag, "_level"}, BtnLevel, expLevel);
    check({tag, "_pulses"}, p, expP);
    check({tag, "_releases"}, r, expR);
  endtask

  task automatic stallCheck(input logic expLevel, input logic endBtn, input string tag);
    int ev = 0;
    tickRun = 1'b0;
    TickClk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      BtnIn = (((i / 25) % 2) == 0) ? ~endBtn : endBtn;
      @(negedge Clk);
      if (BtnPulse !== 1'b0 || BtnRelease !== 1'b0 || BtnLevel !== expLevel) ev++;
    end
    BtnIn = endBtn;
    repeat (5) @(negedge Clk);
    check({tag, "_output_changes"}, ev, 0);
    check({tag, "_level"}, BtnLevel, expLevel);
    tickRun = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    int ep;

    vecs[0]  = '{1'b1, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1, 0};
    vecs[4]  = '{1'b1, 1'b1, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 0, 0};
    vecs[10] = '{1'b0, 1'b1, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 0, 0};
    vecs[12] = '{1'b0, 1'b1, 0, 0};
    vecs[13] = '{1'b0, 1'b0, 0, 1};
    vecs[14] = '{1'b1, 1'b0, 0, 0};
    vecs[15] = '{1'b1, 1'b0, 0, 0};
    vecs[16] = '{1'b0, 1'b0, 0, 0};
    vecs[17] = '{1'b1, 1'b0, 0, 0};
    vecs[18] = '{1'b1, 1'b0, 0, 0};
    vecs[19] = '{1'b1, 1'b0, 0, 0};
    vecs[20] = '{1'b1, 1'b1, 1, 0};
    vecs[21] = '{1'b0, 1'b1, 0, 0};
    vecs[22] = '{1'b0, 1'b1, 0, 0};
    vecs[23] = '{1'b0, 1'b1, 0, 0};
    vecs[24] = '{1'b1, 1'b1, 0, 0};
    vecs[25] = '{1'b0, 1'b1, 0, 0};
    vecs[26] = '{1'b0, 1'b1, 0, 0};
    vecs[27] = '{1'b0, 1'b1, 0, 0};
    vecs[28] = '{1'b0, 1'b0, 0, 1};
    vecs[29] = '{1'b0, 1'b0, 0, 0};

    // Reset held with the button pressed and the tick running.
    Rst   = 1'b0;
    BtnIn = 1'b1;
    bad   = 0;
    repeat (50) begin
      @(negedge Clk);
      if ({BtnLevel, BtnPulse, BtnRelease} !== 3'b000) bad++;
    end
    check("reset_outputs_low", bad, 0);

    Rst = 1'b1;
    n   = 0;
    while (BtnLevel !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("reset_rise_not_early", (n >= 30) ? 1 : 0, 1);
    check("reset_rise_within_bound", (n <= 43) ? 1 : 0, 1);

    // Asynchronous reset while held clears outputs without waiting for a clock.
    repeat (5) @(negedge Clk);
    check("held_before_midreset", BtnLevel, 1);
    Rst = 1'b0;
    #1;
    check("midreset_clears_outputs", {BtnLevel, BtnPulse, BtnRelease}, 0);
    BtnIn = 1'b0;
    repeat (20) @(negedge Clk);
    Rst = 1'b1;

    align();
    for (int i = 0; i < NumVecs; i++)
      runStep(vecs[i].btn, vecs[i].expLevel, vecs[i].expPulses, vecs[i].expReleases,
              $sformatf("step%0d", i));

    stallCheck(1'b0, 1'b0, "stall_idle");

    // Long hold: a single press pulse, plus repeats when the feature is built in.
    align();
    for (int s = 1; s <= 18; s++) begin
      ep = (s == StableTicks) ? 1 : 0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
      if (s >= StableTicks + RepDelay && ((s - StableTicks - RepDelay) % RepRate) == 0) ep = 1;
`endif
      runStep(1'b1, (s >= StableTicks) ? 1'b1 : 1'b0, ep, 0, $sformatf("hold%0d", s));
    end

    stallCheck(1'b1, 1'b1, "stall_held");

    align();
    runStep(1'b0, 1'b1, 0, 0, "final_rel1");
    runStep(1'b0, 1'b1, 0, 0, "final_rel2");
    runStep(1'b0, 1'b1, 0, 0, "final_rel3");
    runStep(1'b0, 1'b0, 0, 1, "final_rel4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
